// File: rtl/key_schedule_seq_pkg.sv
// Shared definitions for the sequential AES key schedule: S-box, xtime,
// FSM state type and the NK legality / derived-size helpers.
package key_schedule_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } ks_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    // GF(2^8) doubling with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic bit nk_legal(input int nk);
        return (nk == 4) || (nk == 6) || (nk == 8);
    endfunction

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic int nw_of(input int nk);
        return 4 * (nk + 7);
    endfunction

endpackage

// File: rtl/key_schedule_seq_if.sv
// Key-load handshake bundle for key_schedule_seq (cipher key in, ready out).
interface key_schedule_seq_if #(
    parameter int NK = 4
);
    // A key transfers on a rising edge where key_valid and key_ready are both
    // high; the source holds key_in stable while key_valid waits for key_ready.
    logic              key_valid;
    logic              key_ready;
    logic [NK*32-1:0]  key_in;

    modport master (output key_valid, output key_in, input key_ready);
    modport slave  (input key_valid, input key_in, output key_ready);
endinterface

// File: rtl/key_schedule_seq_subword.sv
// Single shared RotWord/SubWord unit: optional byte rotation then four S-box lookups.
module key_sched_subword
    import key_schedule_seq_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic        rot,
    output logic [31:0] word_out
);
    logic [31:0] pre;

    assign pre      = rot ? {word_in[23:0], word_in[31:24]} : word_in;
    assign word_out = {sbox(pre[31:24]), sbox(pre[23:16]), sbox(pre[15:8]), sbox(pre[7:0])};
endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion, one word per clock, with a
// registered round-key read port. Optional KEY_SCHED_REV_EN adds rk_rev.
module key_schedule_seq
    import key_schedule_seq_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    key_schedule_seq_if.slave   key_if,
    output logic                busy,
    output logic                done,
    output logic                keys_valid,
    input  logic [3:0]          rk_idx,
`ifdef KEY_SCHED_REV_EN
    input  logic                rk_rev,
`endif
    output logic [127:0]        rk_out,
    output ks_state_t           state_dbg
);
    localparam int NR = nr_of(NK);
    localparam int NW = nw_of(NK);

    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] LAST_W = 6'(NW - 1);
    localparam logic [2:0] P_LAST = 3'(NK - 1);
    localparam logic [3:0] NR_4   = 4'(NR);

    if (!nk_legal(NK)) begin : g_nk_check
        $error("key_schedule_seq: NK must be 4, 6 or 8");
    end

    ks_state_t   state_q, state_d;
    logic [5:0]  i_q;
    logic [2:0]  p_q;
    logic [7:0]  rcon_q;
    logic [31:0] w [NW];

    logic        accept;
    logic        last_word;
    logic [31:0] prev_w, old_w, sub_out, t_w, new_w;

    assign accept    = key_if.key_valid && key_if.key_ready;
    assign last_word = (i_q == LAST_W);
    assign state_dbg = state_q;

    always_comb begin
        state_d           = state_q;
        key_if.key_ready  = 1'b1;
        busy              = 1'b0;
        keys_valid        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_if.key_valid) state_d = EXPAND;
            end
            EXPAND: begin
                key_if.key_ready = 1'b0;
                busy             = 1'b1;
                if (last_word) state_d = READY;
            end
            READY: begin
                keys_valid = 1'b1;
                if (key_if.key_valid) state_d = EXPAND;
            end
            default: state_d = IDLE;
        endcase
    end

    // Recurrence operands: w[i-1] feeds the SubWord unit, w[i-NK] is the XOR partner.
    assign prev_w = w[i_q - 6'd1];
    assign old_w  = w[i_q - NK_W];

    key_sched_subword u_subword (
        .word_in  (prev_w),
        .rot      (p_q == 3'd0),
        .word_out (sub_out)
    );

    always_comb begin
        t_w = prev_w;
        if (p_q == 3'd0)
            t_w = sub_out ^ {rcon_q, 24'h0};
        else if (NK == 8 && p_q == 3'd4)
            t_w = sub_out;
        new_w = old_w ^ t_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            p_q     <= '0;
            rcon_q  <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == EXPAND) && last_word;
            if (accept) begin
                i_q    <= NK_W;
                p_q    <= '0;
                rcon_q <= 8'h01;
            end else if (state_q == EXPAND) begin
                i_q <= i_q + 6'd1;
                p_q <= (p_q == P_LAST) ? 3'd0 : p_q + 3'd1;
                if (p_q == 3'd0) rcon_q <= xtime(rcon_q);
            end
        end
    end

    // Word store is deliberately unreset; keys_valid gates every read of it.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NK; k++)
                w[k] <= key_if.key_in[(NK-1-k)*32 +: 32];
        end else if (state_q == EXPAND) begin
            w[i_q] <= new_w;
        end
    end

    logic [3:0] sel_idx;
    logic       in_range;
    logic [5:0] base;

    always_comb begin
        sel_idx = rk_idx;
`ifdef KEY_SCHED_REV_EN
        if (rk_rev) sel_idx = NR_4 - rk_idx;
`endif
        in_range = (rk_idx <= NR_4);
        base     = in_range ? {sel_idx, 2'b00} : 6'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rk_out <= '0;
        else if (keys_valid && in_range)
            rk_out <= {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
        else
            rk_out <= '0;
    end

endmodule

// File: doc/key_schedule_seq.md
# key_schedule_seq

Sequential, parametrised AES key expansion for AES-128/192/256. It accepts a cipher key over a valid/ready handshake, generates one expanded word per clock into an internal word store, and then serves 128-bit round keys through an indexed, registered read port. It is the area-lean successor to the fully unrolled combinational expansion: it has one SubWord path instead of one per round, and it adds 192- and 256-bit key support.

## Interface
- NK, 4, key length in 32-bit words; legal values 4, 6, 8. Any other value is a elaboration error.
- NR, NK+6, number of rounds (derived; not overridable).
- NW, 4*(NR+1), total expanded words: 44, 52 or 60 (derived).
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key_valid  input  1  key_in holds a key to expand.
- key_ready  output  1  block can accept a key.
- key_in  input  NK*32  cipher key; word 0 is in the MSBs.
- busy  output  1  expansion in progress.
- done  output  1  one-cycle pulse when the last word is written.
- keys_valid  output  1  store holds a complete schedule.
- rk_idx  input  4  round-key index, 0..NR.
- rk_out  output  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, with w[4r] in the MSBs.

## Operation
- FSM states:
  - IDLE: key_ready=1, keys_valid=0.
  - EXPAND: key_ready=0, busy=1.
  - READY: key_ready=1, keys_valid=1.
- Accept: key_valid & key_ready.
  - Load w[0..NK-1] from key_in.
  - Set word counter i=NK, phase counter p=0 (p tracks i mod NK), rcon=8'h01.
  - Go to EXPAND.
  - A new accept in READY clears keys_valid and restarts expansion.
- EXPAND, once per cycle, with t=w[i-1]:
  - If p==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}, then rcon = xtime(rcon) (0x80 -> 0x1b).
  - Else if NK==8 and p==4: t = SubWord(t).
  - Then w[i] = w[i-NK] ^ t; i += 1; p = (p==NK-1) ? 0 : p+1.
  - No division or modulo hardware is used.
- After w[NW-1] is written, go to READY and pulse done.
- key_valid is ignored in EXPAND, since key_ready=0 there.
- Read port:
  - rk_out registers the selected words every cycle.
  - If rk_idx>NR or keys_valid=0, rk_out is all zeros (it never exposes a partial schedule).
- Reset, asynchronous and effective at any point including mid-EXPAND:
  - state=IDLE; i, p, rcon cleared.
  - key_ready=1, busy=0, done=0, keys_valid=0, rk_out=0.
  - The word store is not reset, but it is unreadable until keys_valid rises.

## Timing
- Accept at edge T → load at T, busy=1 from T.
- Words NK..NW-1 are written on edges T+1 … T+NW-NK.
- done and keys_valid rise after edge T+NW-NK; key_ready also returns then.
- Latency from accept to done: 40, 46 or 52 cycles (NK=4, 6, 8).
- Back-to-back: a new key may be accepted in the same cycle that done is high.
- rk_out latency: 1 cycle from rk_idx, keyed to the keys_valid value at that edge.

## Configuration
- KEY_SCHED_REV_EN defined:
  - Adds input port rk_rev (1 bit).
  - When rk_rev=1, rk_out returns round key NR-rk_idx, giving decryption order.
  - Range check and zeroing rules are unchanged.
- Undefined: no rk_rev port; rk_idx maps directly.

## Structure
- Shared package holds:
  - the AES S-box table;
  - the xtime function;
  - the FSM state typedef (IDLE/EXPAND/READY);
  - NK-legal checks and derived NR/NW constants.
- One sub-module, key_sched_subword: a 32-bit RotWord/SubWord unit.
  - Rot is selected by an input.
  - It contains four S-box lookups.
  - It is instantiated once.

## Test plan
- AES-128 expansion:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: done 40 cycles after accept; rk_idx=1 → a0fafe1788542cb123a339392a6c7605; rk_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 expansion:
  - Stimulus: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - Required: done after 46 cycles; rk_idx=12 low word = 01002202.
- AES-256 expansion:
  - Stimulus: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - Required: done after 52 cycles; rk_idx=14 low word = 706c631e (exercises the p==4 SubWord path).
- Reset mid-expansion:
  - Stimulus: rst_n low at cycle 20 of EXPAND, then re-accept the AES-128 key.
  - Required: keys_valid=0 and rk_out=0 immediately; a full correct schedule after 40 cycles.
- Handshake and range:
  - key_valid held during EXPAND is not accepted.
  - rk_idx=11 with NK=4 → zeros.
  - rk_idx read before done → zeros.
  - Re-key in READY drops keys_valid on the next cycle.
- Reverse order (KEY_SCHED_REV_EN):
  - Stimulus: rk_rev=1, rk_idx=0 after the AES-128 key.
  - Required: d014f9a8c9ee2589e13f0cc8b6630ca6.
